mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between instruction fetch (IF) and the MW-stage load/store unit.
- Sequences one outstanding transaction at a time.
- Generates the fetch and MW stall signals consumed by pipeline control.
- Discards in-flight fetch responses killed by a taken branch (PCsrc flush).

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MW load/store unit.
// Only one memory transaction is outstanding at a time; the stall outputs feed pipeline control.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_kill,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_mask,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_mask,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_f,
    output logic            stall_mw
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     r_state;
    logic [3:0] r_d_streak;
    logic       r_kill_pend;

    logic w_if_pend;
    logic w_if_cand;
    logic w_d_cand;
    logic w_grant_i;
    logic w_grant_d;

    // A requester still holding its request during its own ack cycle is not a new request.
    assign w_if_pend = if_req & ~if_ack;
    assign w_if_cand = w_if_pend & ~if_kill & ~r_kill_pend;
    assign w_d_cand  = d_req & ~d_ack;
    assign w_grant_i = w_if_cand & (~w_d_cand | (r_d_streak == STREAK_MAX));
    assign w_grant_d = w_d_cand & ~w_grant_i;

    assign stall_mw = d_req & ~d_ack;
    assign stall_f  = (if_req & ~if_ack) | stall_mw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_d_streak  <= 4'd0;
            r_kill_pend <= 1'b0;
            if_ack      <= 1'b0;
            if_rdata    <= '0;
            d_ack       <= 1'b0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_mask    <= 4'd0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= ST_D_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_mask  <= d_mask;
                        // Saturate at the limit so the forced-fetch compare keeps holding.
                        if (!w_if_pend)
                            r_d_streak <= 4'd0;
                        else if (r_d_streak != STREAK_MAX)
                            r_d_streak <= r_d_streak + 4'd1;
                    end else if (w_grant_i) begin
                        r_state    <= ST_I_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_mask   <= 4'hF;
                        r_d_streak <= 4'd0;
                    end
                end
                ST_I_BUSY: begin
                    if (if_kill)
                        r_kill_pend <= 1'b1;
                    if (mem_ack) begin
                        r_state     <= ST_IDLE;
                        mem_req     <= 1'b0;
                        r_kill_pend <= 1'b0;
                        if (!r_kill_pend && !if_kill) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                ST_D_BUSY: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        mem_req <= 1'b0;
                        d_ack   <= 1'b1;
                        d_rdata <= mem_we ? '0 : mem_rdata;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a responder models the variable-latency memory,
// expected commands and ack data are queued as stimulus is driven and popped as the DUT produces them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_mask = 4'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_f;
    logic        stall_mw;

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_mw(stall_mw)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];

    int total = 0;
    int bad = 0;
    int mem_lat = 1;
    int if_ack_cnt = 0;
    int d_ack_cnt = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0100)
            return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void push_fetch(input logic [31:0] a, input bit acked);
        cmd_t c;
        c.is_d = 1'b0; c.we = 1'b0; c.addr = a; c.wdata = '0; c.mask = 4'hF;
        exp_cmd.push_back(c);
        if (acked)
            exp_if.push_back(word_at(a));
    endfunction

    function automatic void push_data(input logic we, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] m);
        cmd_t c;
        c.is_d = 1'b1; c.we = we; c.addr = a; c.wdata = wd; c.mask = m;
        exp_cmd.push_back(c);
        exp_d.push_back(we ? 32'd0 : word_at(a));
    endfunction

    // Memory responder and output monitor, sampling 1 time unit after each rising edge.
    initial begin : monitor
        bit          seen;
        int          wcnt;
        cmd_t        c;
        logic [68:0] cur;
        logic [31:0] e;
        seen = 1'b0;
        wcnt = 0;
        cur  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_ack = 1'b0;
                seen    = 1'b0;
                wcnt    = 0;
            end else begin
                total++;
                if (stall_mw !== (d_req & ~d_ack)) begin
                    bad++;
                    $display("FAIL stall_mw t=%0t got=%b want=%b", $time, stall_mw, d_req & ~d_ack);
                end
                total++;
                if (stall_f !== ((if_req & ~if_ack) | (d_req & ~d_ack))) begin
                    bad++;
                    $display("FAIL stall_f t=%0t got=%b want=%b", $time, stall_f,
                             (if_req & ~if_ack) | (d_req & ~d_ack));
                end
                if (if_ack === 1'b1) begin
                    if_ack_cnt++;
                    total++;
                    if (exp_if.size() == 0) begin
                        bad++;
                        $display("FAIL if_ack_unexpected t=%0t rdata=%h want=no ack", $time, if_rdata);
                    end else begin
                        e = exp_if.pop_front();
                        if (if_rdata !== e) begin
                            bad++;
                            $display("FAIL if_rdata t=%0t got=%h want=%h", $time, if_rdata, e);
                        end
                    end
                end
                if (d_ack === 1'b1) begin
                    d_ack_cnt++;
                    total++;
                    if (exp_d.size() == 0) begin
                        bad++;
                        $display("FAIL d_ack_unexpected t=%0t rdata=%h want=no ack", $time, d_rdata);
                    end else begin
                        e = exp_d.pop_front();
                        if (d_rdata !== e) begin
                            bad++;
                            $display("FAIL d_rdata t=%0t got=%h want=%h", $time, d_rdata, e);
                        end
                    end
                end
                if (mem_ack) begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    total++;
                    if (mem_req !== 1'b0) begin
                        bad++;
                        $display("FAIL mem_req_drop t=%0t got=%b want=0", $time, mem_req);
                    end
                end else if (mem_req === 1'b1) begin
                    if (!seen) begin
                        seen = 1'b1;
                        cur  = {mem_we, mem_addr, mem_wdata, mem_mask};
                        total++;
                        if (exp_cmd.size() == 0) begin
                            bad++;
                            $display("FAIL grant_unexpected t=%0t addr=%h we=%b want=no grant",
                                     $time, mem_addr, mem_we);
                        end else begin
                            c = exp_cmd.pop_front();
                            if (mem_we !== c.we || mem_addr !== c.addr ||
                                (c.is_d && (mem_wdata !== c.wdata || mem_mask !== c.mask))) begin
                                bad++;
                                $display("FAIL mem_cmd t=%0t got we=%b addr=%h wdata=%h mask=%b want we=%b addr=%h wdata=%h mask=%b",
                                         $time, mem_we, mem_addr, mem_wdata, mem_mask,
                                         c.we, c.addr, c.wdata, c.mask);
                            end
                        end
                    end else begin
                        total++;
                        if ({mem_we, mem_addr, mem_wdata, mem_mask} !== cur) begin
                            bad++;
                            $display("FAIL mem_cmd_stable t=%0t got=%h want=%h", $time,
                                     {mem_we, mem_addr, mem_wdata, mem_mask}, cur);
                        end
                    end
                    if (wcnt >= mem_lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = word_at(mem_addr);
                        wcnt      = 0;
                        seen      = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_if_ack(input int maxc, output int cyc);
        cyc = 0;
        while (if_ack !== 1'b1 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_d_ack(input int maxc, output int cyc);
        cyc = 0;
        while (d_ack !== 1'b1 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake got mem_req=%b if_ack=%b d_ack=%b want 0/0/0", mem_req, if_ack, d_ack);
        end
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_mask !== 4'd0) begin
            bad++;
            $display("FAIL reset_cmd got we=%b addr=%h wdata=%h mask=%b want all 0", mem_we, mem_addr, mem_wdata, mem_mask);
        end
        total++;
        if (if_rdata !== 32'd0 || d_rdata !== 32'd0 || stall_f !== 1'b0 || stall_mw !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got if_rdata=%h d_rdata=%h stall_f=%b stall_mw=%b want all 0", if_rdata, d_rdata, stall_f, stall_mw);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_lone_fetch();
        int cyc;
        mem_lat = 1;
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        push_fetch(32'h0000_0100, 1'b1);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100 || stall_f !== 1'b1) begin
            bad++;
            $display("FAIL fetch_issue got mem_req=%b addr=%h stall_f=%b want 1/00000100/1", mem_req, mem_addr, stall_f);
        end
        wait_if_ack(10, cyc);
        total++;
        if (if_ack !== 1'b1 || cyc != 2) begin
            bad++;
            $display("FAIL fetch_latency got if_ack=%b after %0d cycles want ack after 2", if_ack, cyc);
        end
        total++;
        if (stall_f !== 1'b0) begin
            bad++;
            $display("FAIL fetch_stall_release got stall_f=%b want 0", stall_f);
        end
        @(negedge clk);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_lone_fetch done cycles=%0d", cyc);
    endtask

    task automatic test_simultaneous();
        int cyc;
        mem_lat = 2;
        if_req  = 1'b1;
        if_addr = 32'h0000_0140;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'h1111_2222;
        d_mask  = 4'hF;
        push_data(1'b0, 32'h0000_2000, 32'h1111_2222, 4'hF);
        push_fetch(32'h0000_0140, 1'b1);
        wait_d_ack(20, cyc);
        total++;
        if (d_ack !== 1'b1 || stall_f !== 1'b1) begin
            bad++;
            $display("FAIL simul_data_first got d_ack=%b stall_f=%b want 1/1", d_ack, stall_f);
        end
        @(negedge clk);
        d_req = 1'b0;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0140 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL simul_fetch_next got mem_req=%b addr=%h we=%b want 1/00000140/0", mem_req, mem_addr, mem_we);
        end
        wait_if_ack(20, cyc);
        total++;
        if (if_ack !== 1'b1) begin
            bad++;
            $display("FAIL simul_fetch_ack got if_ack=%b want 1 (timeout)", if_ack);
        end
        @(negedge clk);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_simultaneous done");
    endtask

    task automatic test_starvation();
        int cyc;
        mem_lat = 0;
        for (int k = 0; k < 4; k++)
            push_data(1'b0, 32'h0000_1000 + 32'(4 * k), 32'd0, 4'hF);
        push_fetch(32'h0000_0300, 1'b1);
        push_data(1'b0, 32'h0000_1010, 32'd0, 4'hF);
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
        if_kill = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_wdata = 32'd0;
        d_mask  = 4'hF;
        d_addr  = 32'h0000_1000;
        for (int k = 0; k < 4; k++) begin
            wait_d_ack(20, cyc);
            total++;
            if (d_ack !== 1'b1) begin
                bad++;
                $display("FAIL streak_data_%0d got d_ack=%b want 1 (timeout)", k, d_ack);
            end
            @(negedge clk);
            d_addr = 32'h0000_1000 + 32'(4 * (k + 1));
            if (k == 3)
                if_kill = 1'b0;
        end
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0000_0300) begin
            bad++;
            $display("FAIL streak_forced_fetch got mem_req=%b we=%b addr=%h want 1/0/00000300", mem_req, mem_we, mem_addr);
        end
        wait_if_ack(20, cyc);
        total++;
        if (if_ack !== 1'b1) begin
            bad++;
            $display("FAIL streak_fetch_ack got if_ack=%b want 1 (timeout)", if_ack);
        end
        @(negedge clk);
        if_req = 1'b0;
        wait_d_ack(20, cyc);
        total++;
        if (d_ack !== 1'b1) begin
            bad++;
            $display("FAIL streak_last_data got d_ack=%b want 1 (timeout)", d_ack);
        end
        @(negedge clk);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_starvation done");
    endtask

    task automatic test_killed_fetch();
        int cyc;
        int acks_before;
        mem_lat     = 4;
        acks_before = if_ack_cnt;
        push_fetch(32'h0000_0180, 1'b0);
        push_fetch(32'h0000_0200, 1'b1);
        if_req  = 1'b1;
        if_addr = 32'h0000_0180;
        @(negedge clk);
        @(negedge clk);
        if_kill = 1'b1;
        @(negedge clk);
        if_kill = 1'b0;
        if_addr = 32'h0000_0200;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0180) begin
            bad++;
            $display("FAIL kill_inflight got mem_req=%b addr=%h want 1/00000180", mem_req, mem_addr);
        end
        cyc = 0;
        while (mem_req === 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (mem_req !== 1'b0 || if_ack !== 1'b0) begin
            bad++;
            $display("FAIL kill_no_ack got mem_req=%b if_ack=%b want 0/0", mem_req, if_ack);
        end
        wait_if_ack(20, cyc);
        total++;
        if (if_ack !== 1'b1 || if_ack_cnt - acks_before != 1) begin
            bad++;
            $display("FAIL kill_refetch got if_ack=%b acks=%0d want 1/1", if_ack, if_ack_cnt - acks_before);
        end
        @(negedge clk);
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_killed_fetch done");
    endtask

    task automatic test_store();
        int cyc;
        int acks_before;
        mem_lat     = 2;
        acks_before = d_ack_cnt;
        push_data(1'b1, 32'h0000_2400, 32'hDEAD_BEEF, 4'b0011);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_2400;
        d_wdata = 32'hDEAD_BEEF;
        d_mask  = 4'b0011;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_mask !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL store_cmd got req=%b we=%b mask=%b wdata=%h want 1/1/0011/deadbeef", mem_req, mem_we, mem_mask, mem_wdata);
        end
        wait_d_ack(20, cyc);
        total++;
        if (d_ack !== 1'b1 || d_rdata !== 32'd0) begin
            bad++;
            $display("FAIL store_ack got d_ack=%b d_rdata=%h want 1/00000000", d_ack, d_rdata);
        end
        @(negedge clk);
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (d_ack_cnt - acks_before != 1) begin
            bad++;
            $display("FAIL store_single_ack got %0d acks want 1", d_ack_cnt - acks_before);
        end
        $display("test_store done");
    endtask

    task automatic test_reset_mid();
        int cyc;
        mem_lat = 4;
        push_data(1'b0, 32'h0000_2800, 32'd0, 4'hF);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_2800;
        d_wdata = 32'd0;
        d_mask  = 4'hF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy got mem_req=%b want 1", mem_req);
        end
        rst = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async got mem_req=%b d_ack=%b want 0/0", mem_req, d_ack);
        end
        exp_d.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_data(1'b0, 32'h0000_2800, 32'd0, 4'hF);
        wait_d_ack(20, cyc);
        total++;
        if (d_ack !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_regrant got d_ack=%b want 1 (timeout)", d_ack);
        end
        @(negedge clk);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_reset_mid done");
    endtask

    initial begin : main
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_killed_fetch();
        test_store();
        test_reset_mid();
        total++;
        if (exp_cmd.size() != 0 || exp_if.size() != 0 || exp_d.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got cmd=%0d if=%0d d=%0d left want 0/0/0",
                     exp_cmd.size(), exp_if.size(), exp_d.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
